sccb_cfg_sequencer: RTL and testbench
=====================================

// Module: sccb_cfg_sequencer
// PURPOSE
//  Walks the 16-bit camera config ROM ({reg_addr[15:8], reg_data[7:0]}) from address 0, issues one SCCB
//  register write per entry to the SCCB master, and interprets two reserved entries: 16'hFF_F0 = timed
//  delay, 16'hFF_FF = end of table. Sits between cfg_rom and the SCCB master, and is started once after
//  power-up. It reports busy, done and a sticky error to the top level.
// PARAMETERS
//  CLK_FREQ_HZ  25_000_000  i_clk frequency, used to size the delay counter
//  DELAY_MS     1           duration of one FF_F0 delay entry, in ms
//  MAX_RETRY    2           re-issues of a NACKed write before it is abandoned
// PORTS
//  i_clk          in   1   system clock
//  i_rstn         in   1   synchronous, active-low reset
//  i_start        in   1   1-cycle pulse: begin the sequence (ignored while o_busy=1)
//  o_rom_addr     out  8   ROM address
//  i_rom_data     in   16  ROM data, registered: valid 1 cycle after o_rom_addr changes
//  o_sccb_valid   out  1   write request; held until accepted
//  i_sccb_ready   in   1   master can accept; transfer when valid & ready both high on a rising edge
//  o_sccb_addr    out  8   register address (i_rom_data[15:8]); stable while o_sccb_valid=1
//  o_sccb_data    out  8   register value (i_rom_data[7:0]); stable while o_sccb_valid=1
//  i_sccb_done    in   1   1-cycle pulse when the accepted write completes on the bus
//  i_sccb_nack    in   1   qualifies i_sccb_done: 1 = camera NACKed
//  o_busy         out  1   high from the cycle after the accepted i_start until entry to DONE
//  o_done         out  1   level; high in DONE, cleared by the next accepted i_start
//  o_err          out  1   sticky; set when any entry exhausts its retries, cleared on accepted i_start
// BEHAVIOUR
//  - Reset: state=IDLE. o_rom_addr=0, o_sccb_valid=0, o_sccb_addr=0, o_sccb_data=0, o_busy=0, o_done=0,
//    o_err=0. Retry and delay counters = 0. Reset mid-operation aborts immediately; a pending
//    o_sccb_valid drops on the reset cycle.
//  - States: IDLE -> FETCH -> ROMWAIT -> DECODE -> {ISSUE | DELAY | DONE}; ISSUE -> ACKWAIT -> NEXT;
//    DELAY -> NEXT; NEXT -> FETCH or DONE; DONE -> FETCH on i_start.
//  - IDLE/DONE: on i_start, set o_rom_addr=0, clear o_done and o_err, go to FETCH.
//  - FETCH (1 cycle): the address is stable. ROMWAIT (1 cycle): the ROM registers the data.
//    DECODE samples i_rom_data. First read to decode is therefore 2 cycles.
//  - DECODE:
//      FF_FF -> DONE.
//      FF_F0 -> DELAY, counter loaded with CLK_FREQ_HZ/1000*DELAY_MS-1.
//      Any other value -> latch addr/data into o_sccb_addr/o_sccb_data, assert o_sccb_valid, go to
//      ISSUE. Entries FF_xx other than F0/FF are written as normal registers.
//  - ISSUE: hold o_sccb_valid until i_sccb_ready=1. On that edge, drop valid and go to ACKWAIT.
//  - ACKWAIT: wait for i_sccb_done.
//      nack=0 -> NEXT.
//      nack=1 and retry<MAX_RETRY -> retry++, reassert valid with the same addr/data, go to ISSUE.
//      nack=1 and retry==MAX_RETRY -> set o_err, go to NEXT (the entry is skipped).
//    i_sccb_done outside ACKWAIT is ignored.
//  - DELAY: decrement each cycle and exit to NEXT on the cycle the counter is 0. Total DELAY residency
//    = CLK_FREQ_HZ/1000*DELAY_MS cycles.
//  - NEXT: clear retry.
//      o_rom_addr==8'hFF -> DONE (no wrap; a missing terminator ends after entry 255).
//      Otherwise o_rom_addr++ and go to FETCH.
//  - i_start while busy is ignored. i_start in the same cycle as entering DONE is also ignored.
//  - Delay counter width = $clog2(CLK_FREQ_HZ/1000*DELAY_MS)+1. No other arithmetic beyond the 8-bit
//    address increment.
// TESTING
//  1) ROM model {12_80, 11_00, FF_FF}, ready=1, done 3 cycles after accept, nack=0 -> two writes
//     (12/80, 11/00) in order; o_done=1, o_err=0, o_rom_addr=2.
//  2) CLK_FREQ_HZ=1_000_000 with {12_80, FF_F0, 11_00, FF_FF} -> exactly 1000 cycles in DELAY between
//     done of write 1 and valid of write 2.
//  3) MAX_RETRY=2, camera NACKs entry 0 always -> 3 accepts of 12/80, o_err=1, entry 1 still written,
//     o_done=1.
//  4) Ready held low 50 cycles -> o_sccb_valid stays high with addr/data constant, then 1 accept only.
//  5) i_start pulsed while busy -> no restart. Reset asserted in DELAY -> all outputs 0 next cycle;
//     a new i_start replays from address 0.
//  6) 256 entries without FF_FF -> 256 writes; DONE after address 255; o_rom_addr=8'hFF (no wrap).

Source files
------------

// File: rtl/sccb_cfg_sequencer.sv
// Walks the camera config ROM and turns each entry into one SCCB register write,
// honouring timed-delay (FF_F0) and end-of-table (FF_FF) marker entries.
module sccb_cfg_sequencer #(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned DELAY_MS    = 1,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic        o_sccb_valid,
    input  logic        i_sccb_ready,
    output logic [7:0]  o_sccb_addr,
    output logic [7:0]  o_sccb_data,
    input  logic        i_sccb_done,
    input  logic        i_sccb_nack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int unsigned CNT_W        = $clog2(DELAY_CYCLES) + 1;
    localparam int unsigned RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   DELAY_LOAD  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY);
    localparam logic [15:0]        ENTRY_DELAY = 16'hFFF0;
    localparam logic [15:0]        ENTRY_END   = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ROMWAIT,
        ST_DECODE,
        ST_ISSUE,
        ST_ACKWAIT,
        ST_DELAY,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   delay_cnt;
    logic [RETRY_W-1:0] retry;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (i_start) state_nx = ST_FETCH;
            end
            ST_FETCH:   state_nx = ST_ROMWAIT;
            ST_ROMWAIT: state_nx = ST_DECODE;
            ST_DECODE: begin
                if (i_rom_data == ENTRY_END)        state_nx = ST_DONE;
                else if (i_rom_data == ENTRY_DELAY) state_nx = ST_DELAY;
                else                                state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (i_sccb_ready) state_nx = ST_ACKWAIT;
            end
            ST_ACKWAIT: begin
                if (i_sccb_done) begin
                    if (i_sccb_nack && (retry != RETRY_LAST)) state_nx = ST_ISSUE;
                    else                                       state_nx = ST_NEXT;
                end
            end
            ST_DELAY: begin
                if (delay_cnt == '0) state_nx = ST_NEXT;
            end
            ST_NEXT: begin
                // Table without terminator stops after entry 255 rather than wrapping.
                if (o_rom_addr == 8'hFF) state_nx = ST_DONE;
                else                     state_nx = ST_FETCH;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_rom_addr  <= '0;
            o_sccb_addr <= '0;
            o_sccb_data <= '0;
            o_err       <= 1'b0;
            retry       <= '0;
            delay_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        o_rom_addr <= '0;
                        o_err      <= 1'b0;
                        retry      <= '0;
                    end
                end
                ST_DECODE: begin
                    if (i_rom_data == ENTRY_DELAY) begin
                        delay_cnt <= DELAY_LOAD;
                    end else if (i_rom_data != ENTRY_END) begin
                        o_sccb_addr <= i_rom_data[15:8];
                        o_sccb_data <= i_rom_data[7:0];
                    end
                end
                ST_ACKWAIT: begin
                    if (i_sccb_done && i_sccb_nack) begin
                        if (retry == RETRY_LAST) o_err <= 1'b1;
                        else                     retry <= retry + RETRY_W'(1);
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt != '0) delay_cnt <= delay_cnt - CNT_W'(1);
                end
                ST_NEXT: begin
                    retry <= '0;
                    if (o_rom_addr != 8'hFF) o_rom_addr <= o_rom_addr + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_sccb_valid = (state == ST_ISSUE);
        o_busy       = (state != ST_IDLE) && (state != ST_DONE);
        o_done       = (state == ST_DONE);
    end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Scoreboard bench: a table-level model predicts every write attempt and its start latency;
// a monitor checks each presented write, and a responder plays the SCCB master.
module tb_sccb_cfg_sequencer;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned DMS    = 1;
    localparam int unsigned MAXR   = 2;
    localparam int unsigned NDLY   = CLK_HZ / 1000 * DMS;
    localparam int unsigned BOUND  = 40000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_q;
    logic        sccb_valid;
    logic        sccb_ready = 1'b0;
    logic [7:0]  sccb_addr;
    logic [7:0]  sccb_data;
    logic        sccb_done = 1'b0;
    logic        sccb_nack = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    sccb_cfg_sequencer #(
        .CLK_FREQ_HZ(CLK_HZ),
        .DELAY_MS   (DMS),
        .MAX_RETRY  (MAXR)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_start     (start),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_q),
        .o_sccb_valid(sccb_valid),
        .i_sccb_ready(sccb_ready),
        .o_sccb_addr (sccb_addr),
        .o_sccb_data (sccb_data),
        .i_sccb_done (sccb_done),
        .i_sccb_nack (sccb_nack),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) rom_q <= rom[rom_addr];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  d;
        int unsigned gap;
    } wr_t;

    wr_t         exp_q[$];
    bit          nack_q[$];
    int unsigned nack_plan[256];
    int unsigned last_evt = 0;
    int unsigned ready_hold = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_addr;
    logic        exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: walk the table, expand each register entry into its write attempts,
    // and predict how many cycles after the previous start/done event each attempt appears.
    task automatic build_model();
        int unsigned delays = 0;
        bit first = 1'b1;
        exp_q.delete();
        nack_q.delete();
        exp_err  = 1'b0;
        exp_addr = 8'hFF;
        for (int unsigned a = 0; a < 256; a++) begin
            if (rom[a] == 16'hFFFF) begin
                exp_addr = a[7:0];
                break;
            end
            if (rom[a] == 16'hFFF0) begin
                delays++;
                continue;
            end
            for (int unsigned t = 0; t <= MAXR; t++) begin
                wr_t w;
                w.a   = rom[a][15:8];
                w.d   = rom[a][7:0];
                w.gap = (t > 0) ? 1 : ((first ? 4 : 5) + delays * (NDLY + 4));
                exp_q.push_back(w);
                nack_q.push_back(t < nack_plan[a]);
                if (t >= nack_plan[a]) break;
            end
            if (nack_plan[a] > MAXR) exp_err = 1'b1;
            first  = 1'b0;
            delays = 0;
        end
    endtask

    // SCCB master model: random ready, done 1..4 cycles after accept with the planned nack.
    initial begin
        int unsigned pend = 0;
        bit pnack = 1'b0;
        forever begin
            @(negedge clk);
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
            if (!rstn) begin
                pend       = 0;
                sccb_ready = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        sccb_done = 1'b1;
                        sccb_nack = pnack;
                    end
                end
                if (ready_hold > 0) begin
                    sccb_ready = 1'b0;
                    ready_hold--;
                end else begin
                    sccb_ready = ($urandom_range(0, 3) != 0);
                end
                if (sccb_valid && sccb_ready) begin
                    pend  = $urandom_range(1, 4);
                    pnack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                end
            end
        end
    end

    // Monitor: every cycle a write is presented it must match the head of the scoreboard.
    initial begin
        bit pv = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                pv = 1'b0;
            end else begin
                if (sccb_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_write: got %0h/%0h, expected none (cycle %0d)",
                                 sccb_addr, sccb_data, cyc);
                    end else begin
                        check("wr_addr", 32'(sccb_addr), 32'(exp_q[0].a));
                        check("wr_data", 32'(sccb_data), 32'(exp_q[0].d));
                        if (!pv) check("wr_gap", cyc - last_evt, exp_q[0].gap);
                        if (sccb_ready) void'(exp_q.pop_front());
                    end
                end
                if (sccb_done) last_evt = cyc;
                pv = sccb_valid;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start    = 1'b1;
        last_evt = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int unsigned k = 0;
        while (!(done && exp_q.size() == 0) && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        check({name, "_finished"}, 32'(k < BOUND), 32'd1);
        check({name, "_done"},     32'(done),     32'd1);
        check({name, "_busy"},     32'(busy),     32'd0);
        check({name, "_err"},      32'(err),      32'(exp_err));
        check({name, "_rom_addr"}, 32'(rom_addr), 32'(exp_addr));
        check({name, "_left"},     exp_q.size(),  32'd0);
    endtask

    task automatic run(input string name);
        build_model();
        pulse_start();
        wait_done(name);
    endtask

    task automatic clear_table();
        for (int unsigned i = 0; i < 256; i++) begin
            rom[i]       = 16'hFFFF;
            nack_plan[i] = 0;
        end
    endtask

    function automatic logic [15:0] rand_entry();
        logic [15:0] v;
        do v = 16'($urandom); while (v == 16'hFFF0 || v == 16'hFFFF);
        return v;
    endfunction

    task automatic check_all_zero(input string name);
        check({name, "_rom_addr"}, 32'(rom_addr),   32'd0);
        check({name, "_valid"},    32'(sccb_valid), 32'd0);
        check({name, "_addr"},     32'(sccb_addr),  32'd0);
        check({name, "_data"},     32'(sccb_data),  32'd0);
        check({name, "_busy"},     32'(busy),       32'd0);
        check({name, "_done"},     32'(done),       32'd0);
        check({name, "_err"},      32'(err),        32'd0);
    endtask

    initial begin
        clear_table();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        rom[0] = 16'h1280; rom[1] = 16'h1100;
        run("basic");

        clear_table();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1100;
        run("delay");

        clear_table();
        rom[0] = 16'h1280; rom[1] = 16'h1100; nack_plan[0] = 3;
        run("nack_always");
        nack_plan[0] = 2;
        run("nack_twice");
        nack_plan[0] = 0;

        // Ready stalled ~50 cycles, plus a start pulse while busy that must be ignored.
        build_model();
        ready_hold = 54;
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("stall_restart");

        clear_table();
        rom[0] = 16'hFFF0; rom[1] = 16'h1234;
        build_model();
        pulse_start();
        repeat (200) @(negedge clk);
        check("busy_in_delay", 32'(busy), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        rstn = 1'b1;
        exp_q.delete();
        nack_q.delete();
        run("replay");

        clear_table();
        for (int unsigned i = 0; i < 256; i++) begin
            rom[i]       = rand_entry();
            nack_plan[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        end
        rom[7] = 16'hFF01;
        run("full_table");

        for (int unsigned r = 0; r < 4; r++) begin
            int unsigned len;
            clear_table();
            len = $urandom_range(1, 24);
            for (int unsigned i = 0; i < len; i++) begin
                rom[i]       = ($urandom_range(0, 11) == 0) ? 16'hFFF0 : rand_entry();
                nack_plan[i] = $urandom_range(0, 3);
            end
            run("random_table");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
